// File: rtl/st_unit_pkg.sv
// Shared definitions for the MEM-stage store path: store funct3 encodings,
// FSM state type, byte masks and small helpers for mask/split decoding.
package st_unit_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } st_state_e;

    // An all-zero mask marks an illegal funct3.
    function automatic logic [3:0] st_mask(input logic [2:0] funct3);
        case (funct3)
            F3_SB:   return MASK_B;
            F3_SH:   return MASK_H;
            F3_SW:   return MASK_W;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic st_split(input logic [3:0] mask, input logic [1:0] off);
        logic [7:0] wide;
        wide = {4'b0000, mask} << off;
        return |wide[7:4];
    endfunction

endpackage

// File: rtl/st_unit_if.sv
// Request (EX/MEM side) and data-memory write-beat signals of the store unit.
interface st_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_data;

    logic        dm_wvalid;
    logic        dm_wready;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;

    logic        st_err;
    logic        busy;

    modport slave (
        input  req_valid, req_funct3, req_addr, req_data, dm_wready,
        output req_ready, dm_wvalid, dm_addr, dm_wdata, dm_wstrb, st_err, busy
    );

    modport master (
        output req_valid, req_funct3, req_addr, req_data, dm_wready,
        input  req_ready, dm_wvalid, dm_addr, dm_wdata, dm_wstrb, st_err, busy
    );

endinterface

// File: rtl/st_align.sv
// Lane alignment of a store: places right-justified data and its byte mask at
// the byte offset; beat selects the low word (first beat) or the spill word.
module st_align (
    input  logic [31:0] data,
    input  logic [1:0]  off,
    input  logic [3:0]  mask,
    input  logic        beat,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb
);

    logic [63:0] wide_data;
    logic [7:0]  wide_strb;

    // The upper half of the 64-bit image is exactly the data >> 8*(4-off) spill.
    assign wide_data = {32'b0, data} << {off, 3'b000};
    assign wide_strb = {4'b0000, mask} << off;

    assign wdata = beat ? wide_data[63:32] : wide_data[31:0];
    assign wstrb = beat ? wide_strb[7:4]   : wide_strb[3:0];

endmodule

// File: rtl/st_unit.sv
// Store unit: accepts store requests and issues one or two word-aligned write
// beats with byte strobes; word-crossing stores split into two beats.
module st_unit
    import st_unit_pkg::*;
#(
    parameter bit ALLOW_SPLIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    st_unit_if.slave   bus
);

    st_state_e   state;
    st_state_e   state_next;
    logic        err_q;
    logic        err_next;

    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  mask_q;
    logic        split_q;

    logic [3:0]  req_mask;
    logic        req_split;
    logic        req_ok;
    logic        last_beat;
    logic        ready;
    logic        accept;
    logic        beat_valid;
    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;

    assign req_mask  = st_mask(bus.req_funct3);
    assign req_split = st_split(req_mask, bus.req_addr[1:0]);
    assign req_ok    = (req_mask != 4'b0000) & (~req_split | ALLOW_SPLIT);

    assign last_beat = ((state == ST_BEAT0) & ~split_q) | (state == ST_BEAT1);
    assign ready     = (state == ST_IDLE) | (last_beat & bus.dm_wready);
    assign accept    = bus.req_valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= err_next;
        end
    end

    // NOTE: request registers carry no reset; every dm_* output is gated by
    // the state, so their contents are never visible outside a beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.req_addr;
            data_q  <= bus.req_data;
            mask_q  <= req_mask;
            split_q <= req_split;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            ST_IDLE:  state_next = ST_IDLE;
            ST_BEAT0: if (bus.dm_wready) state_next = split_q ? ST_BEAT1 : ST_IDLE;
            ST_BEAT1: if (bus.dm_wready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        // A request is only accepted once the current store has finished.
        if (accept) begin
            if (req_ok) begin
                state_next = ST_BEAT0;
            end else begin
                state_next = ST_IDLE;
                err_next   = 1'b1;
            end
        end
    end

    st_align u_align (
        .data  (data_q),
        .off   (addr_q[1:0]),
        .mask  (mask_q),
        .beat  (state == ST_BEAT1),
        .wdata (al_wdata),
        .wstrb (al_wstrb)
    );

    assign beat_valid    = (state != ST_IDLE);
    assign bus.req_ready = ready;
    assign bus.dm_wvalid = beat_valid;
    assign bus.dm_addr   = beat_valid
                         ? ({addr_q[31:2], 2'b00} + ((state == ST_BEAT1) ? 32'd4 : 32'd0))
                         : 32'd0;
    assign bus.dm_wdata  = beat_valid ? al_wdata : 32'd0;
    assign bus.dm_wstrb  = beat_valid ? al_wstrb : 4'b0000;
    assign bus.st_err    = err_q;
    assign bus.busy      = beat_valid;

endmodule

// File: tb/tb_st_unit.sv
// Bench for st_unit: directed cases plus random stores on two instances
// (splitting enabled and disabled), checked against a byte-level store model.
module tb_st_unit;
    import st_unit_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    logic clk;
    logic rst;

    st_unit_if bus  ();
    st_unit_if bus2 ();

    assign bus2.req_valid  = bus.req_valid;
    assign bus2.req_funct3 = bus.req_funct3;
    assign bus2.req_addr   = bus.req_addr;
    assign bus2.req_data   = bus.req_data;
    assign bus2.dm_wready  = bus.dm_wready;

    st_unit #(.ALLOW_SPLIT(1'b1)) dut    (.clk(clk), .rst(rst), .bus(bus));
    st_unit #(.ALLOW_SPLIT(1'b0)) dut_ns (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    beat_t mq [2][$];
    bit    merr [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Store semantics: bytes addr..addr+size-1 are written; a byte that lands
    // in the following word goes to a second beat. Data image is data << 8*off.
    function automatic void model_req(input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] data, input bit allow,
                                      output beat_t b0, output beat_t b1,
                                      output int n, output bit err);
        int          size;
        logic [31:0] a;
        logic [63:0] image;
        case (f3)
            3'b000:  size = 1;
            3'b001:  size = 2;
            3'b010:  size = 4;
            default: size = 0;
        endcase
        image    = {32'b0, data} << (8 * int'(addr[1:0]));
        b0.addr  = {addr[31:2], 2'b00};
        b1.addr  = {addr[31:2], 2'b00} + 32'd4;
        b0.wdata = image[31:0];
        b1.wdata = image[63:32];
        b0.strb  = 4'b0000;
        b1.strb  = 4'b0000;
        for (int i = 0; i < size; i++) begin
            a = addr + 32'(i);
            if (a[31:2] == addr[31:2]) b0.strb[a[1:0]] = 1'b1;
            else                       b1.strb[a[1:0]] = 1'b1;
        end
        n   = (b1.strb != 4'b0000) ? 2 : 1;
        err = (size == 0) || (n == 2 && !allow);
        if (err) n = 0;
    endfunction

    task automatic cmp_dut(input int k, input logic v, input logic rdy, input logic err,
                           input logic bsy, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        string p;
        bit    exp_v;
        bit    exp_rdy;
        p       = (k == 0) ? "split" : "nosplit";
        exp_v   = mq[k].size() > 0;
        exp_rdy = (mq[k].size() == 0) || (mq[k].size() == 1 && bus.dm_wready);
        check({p, ".wvalid"},    32'(v),   32'(exp_v));
        check({p, ".busy"},      32'(bsy), 32'(exp_v));
        check({p, ".req_ready"}, 32'(rdy), 32'(exp_rdy));
        check({p, ".st_err"},    32'(err), 32'(merr[k]));
        if (exp_v) begin
            check({p, ".dm_addr"},  a,     mq[k][0].addr);
            check({p, ".dm_wdata"}, d,     mq[k][0].wdata);
            check({p, ".dm_wstrb"}, 32'(s), 32'(mq[k][0].strb));
        end
    endtask

    // One clock: compare both DUTs against the model, then advance the model.
    task automatic tick();
        bit          pop [2];
        bit          acc [2];
        logic [2:0]  f3;
        logic [31:0] a, d;
        logic        r;
        beat_t       b0, b1;
        int          n;
        bit          e;
        cmp_dut(0, bus.dm_wvalid, bus.req_ready, bus.st_err, bus.busy,
                bus.dm_addr, bus.dm_wdata, bus.dm_wstrb);
        cmp_dut(1, bus2.dm_wvalid, bus2.req_ready, bus2.st_err, bus2.busy,
                bus2.dm_addr, bus2.dm_wdata, bus2.dm_wstrb);
        for (int k = 0; k < 2; k++) begin
            pop[k] = (mq[k].size() > 0) && bus.dm_wready;
            acc[k] = bus.req_valid &&
                     ((mq[k].size() == 0) || (mq[k].size() == 1 && bus.dm_wready));
        end
        f3 = bus.req_funct3;
        a  = bus.req_addr;
        d  = bus.req_data;
        r  = rst;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                mq[k].delete();
                merr[k] = 1'b0;
            end else begin
                if (pop[k]) void'(mq[k].pop_front());
                merr[k] = 1'b0;
                if (acc[k]) begin
                    model_req(f3, a, d, (k == 0), b0, b1, n, e);
                    if (e) merr[k] = 1'b1;
                    else begin
                        mq[k].push_back(b0);
                        if (n == 2) mq[k].push_back(b1);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic wr, input logic r);
        bus.req_valid  = v;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_data   = d;
        bus.dm_wready  = wr;
        rst            = r;
        #1;
    endtask

    task automatic idle(input logic wr);
        drive(1'b0, F3_SB, 32'd0, 32'd0, wr, 1'b0);
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s);
        check({tag, ".wvalid"}, 32'(bus.dm_wvalid), 32'd1);
        check({tag, ".addr"},   bus.dm_addr,        a);
        check({tag, ".wdata"},  bus.dm_wdata,       d);
        check({tag, ".strb"},   32'(bus.dm_wstrb),  32'(s));
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel;

        drive(1'b0, F3_SB, 32'd0, 32'd0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle(1'b1);
        check("reset.wvalid", 32'(bus.dm_wvalid), 32'd0);
        check("reset.addr",   bus.dm_addr,        32'd0);
        check("reset.wdata",  bus.dm_wdata,       32'd0);
        check("reset.strb",   32'(bus.dm_wstrb),  32'd0);
        check("reset.err",    32'(bus.st_err),    32'd0);
        check("reset.busy",   32'(bus.busy),      32'd0);
        tick();

        // SB at the top byte lane
        drive(1'b1, F3_SB, 32'h0000_1003, 32'hAABB_CCDD, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        expect_beat("sb_1003", 32'h0000_1000, 32'hDD00_0000, 4'b1000);
        tick();

        // Aligned SW: ready again during its only beat
        drive(1'b1, F3_SW, 32'h0000_2000, 32'h1234_5678, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        expect_beat("sw_2000", 32'h0000_2000, 32'h1234_5678, 4'b1111);
        check("sw_2000.ready", 32'(bus.req_ready), 32'd1);
        tick();

        // Split SW, then a back-to-back SB taken during the second beat
        drive(1'b1, F3_SW, 32'h0000_2002, 32'h1234_5678, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        expect_beat("sw_2002.b0", 32'h0000_2000, 32'h5678_0000, 4'b1100);
        check("sw_2002.b0_ready", 32'(bus.req_ready), 32'd0);
        tick();
        drive(1'b1, F3_SB, 32'h0000_6002, 32'h0000_0099, 1'b1, 1'b0);
        expect_beat("sw_2002.b1", 32'h0000_2004, 32'h0000_1234, 4'b0011);
        check("b2b.ready", 32'(bus.req_ready), 32'd1);
        tick();
        idle(1'b1);
        expect_beat("b2b.sb", 32'h0000_6000, 32'h0099_0000, 4'b0100);
        tick();

        // SH at the last byte of the address space wraps; no-split unit errors
        drive(1'b1, F3_SH, 32'hFFFF_FFFF, 32'h1234_BEEF, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        expect_beat("sh_wrap.b0", 32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000);
        check("nosplit.sh_err",    32'(bus2.st_err),    32'd1);
        check("nosplit.sh_wvalid", 32'(bus2.dm_wvalid), 32'd0);
        tick();
        expect_beat("sh_wrap.b1", 32'h0000_0000, 32'h0012_34BE, 4'b0001);
        check("nosplit.sh_err_end", 32'(bus2.st_err), 32'd0);
        tick();

        // Illegal funct3
        drive(1'b1, 3'b011, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        check("f3_011.err",    32'(bus.st_err),    32'd1);
        check("f3_011.wvalid", 32'(bus.dm_wvalid), 32'd0);
        tick();
        check("f3_011.err_end", 32'(bus.st_err), 32'd0);
        tick();

        // Back-pressure: beat held stable for three cycles
        drive(1'b1, F3_SW, 32'h0000_3001, 32'hCAFE_F00D, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            expect_beat("stall.b0", 32'h0000_3000, 32'hFEF0_0D00, 4'b1110);
            tick();
        end
        idle(1'b1);
        tick();
        expect_beat("stall.b1", 32'h0000_3004, 32'h0000_00CA, 4'b0001);
        tick();

        // Reset during the second beat, then a fresh SB
        drive(1'b1, F3_SW, 32'h0000_4003, 32'h1122_3344, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        tick();
        drive(1'b0, F3_SB, 32'd0, 32'd0, 1'b0, 1'b1);
        check("rst_b1.in_beat1", 32'(bus.dm_addr), 32'h0000_4004);
        tick();
        idle(1'b1);
        check("rst_b1.wvalid", 32'(bus.dm_wvalid), 32'd0);
        check("rst_b1.busy",   32'(bus.busy),      32'd0);
        drive(1'b1, F3_SB, 32'h0000_5001, 32'h0000_0077, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        expect_beat("post_rst.sb", 32'h0000_5000, 32'h0000_7700, 4'b0010);
        tick();

        // Random traffic on both instances
        for (int c = 0; c < 1500; c++) begin
            sel = $urandom_range(0, 7);
            f3  = (sel < 6) ? 3'(sel % 3) : 3'($urandom_range(3, 7));
            a   = $urandom;
            if ($urandom_range(0, 15) == 0) a = {30'h3FFF_FFFF, a[1:0]};
            drive(1'($urandom_range(0, 1)), f3, a, $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
            tick();
        end
        idle(1'b1);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
